// File: rtl/ps2_scancode_receiver_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 scancode receiver slice:
//   FSM state encoding, special scancode values, frame geometry and a
//   parity helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam logic [7:0]  EXT_CODE   = 8'hE0;

    // start + 8 data + parity + stop
    localparam int unsigned FRAME_LEN  = 11;
    localparam int unsigned DATA_BITS  = FRAME_LEN - 3;

    // Odd parity over the data byte plus the received parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_scancode_receiver_if.sv
// ---------------------------------------------------------------------------
// ps2_scancode_receiver_if
//   Bundles the PS/2 line inputs and the decoded scancode outputs.
//   slave  : the receiver (consumes ps2_clk/ps2_data, drives results)
//   master : the line/device side and downstream consumer
//   Signals:
//     ps2_clk, ps2_data : raw asynchronous PS/2 lines
//     scancode[7:0]     : last accepted byte
//     flag              : one-cycle pulse on scancode update
//     frame_err         : one-cycle pulse on a rejected/timed-out frame
//     busy              : frame in progress
// ---------------------------------------------------------------------------
interface ps2_scancode_receiver_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       flag;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output scancode,
        output flag,
        output frame_err,
        output busy
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  scancode,
        input  flag,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/ps2_scancode_receiver_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
//   Synchronises ps2_clk/ps2_data into vga_clk, glitch-filters the clock
//   (new level must persist FILTER_LEN cycles) and emits sample_evt on each
//   filtered 1->0 transition, with data_s aligned to that pulse.
//   Ports:
//     vga_clk, reset   : system clock, async active-high reset
//     i_ps2_clk        : raw PS/2 clock
//     i_ps2_data       : raw PS/2 data
//     o_sample_evt     : one-cycle pulse on filtered falling edge
//     o_data_s         : synchronised data, valid with o_sample_evt
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic vga_clk,
    input  logic reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_sample_evt,
    output logic o_data_s
);

    localparam int unsigned CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_f;
    logic [CW-1:0]          r_cnt;
    logic                   r_evt;
    logic                   r_data_s;
    logic                   w_clk_s;
    logic                   w_data_s;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];

    // Idle PS/2 lines are high; resetting the chains to 1 avoids a
    // spurious falling edge right after reset.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
        end
    end

    // r_cnt counts consecutive cycles the synchronised clock disagrees
    // with the filtered one; the FILTER_LEN-th such cycle commits the change.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_clk_f  <= 1'b1;
            r_cnt    <= '0;
            r_evt    <= 1'b0;
            r_data_s <= 1'b1;
        end else begin
            r_evt    <= 1'b0;
            r_data_s <= w_data_s;
            if (w_clk_s != r_clk_f) begin
                if (r_cnt == CW'(FILTER_LEN - 1)) begin
                    r_clk_f <= w_clk_s;
                    r_cnt   <= '0;
                    r_evt   <= ~w_clk_s;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_sample_evt = r_evt;
    assign o_data_s     = r_data_s;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// ---------------------------------------------------------------------------
// ps2_scancode_receiver
//   PS/2 device-to-host frame receiver. Deframes 11-bit frames, checks odd
//   parity and stop bit, enforces an inter-edge timeout and presents each
//   valid byte as a registered scancode with a one-cycle flag.
//   Ports:
//     vga_clk : system clock (25 MHz)
//     reset   : asynchronous, active-high
//     bus     : ps2_scancode_receiver_if.slave
//               (ps2_clk, ps2_data in; scancode, flag, frame_err, busy out)
//   Optional build macro: PS2_BREAK_FILTER_EN
//     When defined, an F0 byte and the byte following it produce no flag
//     (F0 itself does not update scancode; the next byte does).
// ---------------------------------------------------------------------------
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                    vga_clk,
    input  logic                    reset,
    ps2_scancode_receiver_if.slave  bus
);

    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic       w_sample_evt;
    logic       w_data_s;

    ps2_state_t r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_parity;
    logic [TW-1:0] r_tcnt;
    logic [7:0] r_scancode;
    logic       r_flag;
    logic       r_err;
    logic       r_busy;
`ifdef PS2_BREAK_FILTER_EN
    logic       r_brk;
`endif

    ps2_line_filter #(
        .FILTER_LEN  (FILTER_LEN),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_filter (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .i_ps2_clk    (bus.ps2_clk),
        .i_ps2_data   (bus.ps2_data),
        .o_sample_evt (w_sample_evt),
        .o_data_s     (w_data_s)
    );

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_parity   <= 1'b0;
            r_tcnt     <= '0;
            r_scancode <= '0;
            r_flag     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            r_brk      <= 1'b0;
`endif
        end else begin
            r_flag <= 1'b0;
            r_err  <= 1'b0;

            // Saturating inter-edge timer, cleared in IDLE and per sample.
            if (r_state == IDLE || w_sample_evt)
                r_tcnt <= '0;
            else if (r_tcnt != TMAX)
                r_tcnt <= r_tcnt + 1'b1;

            if (w_sample_evt) begin
                case (r_state)
                    IDLE: begin
                        if (!w_data_s) begin
                            r_state  <= DATA;
                            r_busy   <= 1'b1;
                            r_bitcnt <= '0;
                            r_shift  <= '0;
                        end
                    end
                    DATA: begin
                        r_shift  <= {w_data_s, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'(DATA_BITS - 1))
                            r_state <= PARITY;
                    end
                    PARITY: begin
                        r_parity <= w_data_s;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_data_s && odd_parity_ok(r_shift, r_parity)) begin
`ifdef PS2_BREAK_FILTER_EN
                            if (r_shift == BREAK_CODE) begin
                                r_brk <= 1'b1;
                            end else begin
                                r_scancode <= r_shift;
                                r_flag     <= ~r_brk;
                                r_brk      <= 1'b0;
                            end
`else
                            r_scancode <= r_shift;
                            r_flag     <= 1'b1;
`endif
                        end else begin
                            r_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                            r_brk <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (r_state != IDLE && r_tcnt == TMAX) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                r_brk   <= 1'b0;
`endif
            end
        end
    end

    assign bus.scancode  = r_scancode;
    assign bus.flag      = r_flag;
    assign bus.frame_err = r_err;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_receiver
//   Directed, table-driven bench for ps2_scancode_receiver. PS/2 half-period
//   is shortened to 60 vga_clk cycles to keep run time small.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_receiver;

    localparam int H = 60;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    ps2_scancode_receiver_if u_if ();

    ps2_scancode_receiver #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (5000),
        .SYNC_STAGES    (2)
    ) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (u_if)
    );

    always #20 vga_clk = ~vga_clk;

    int total = 0;
    int bad   = 0;

    int       n_flag = 0;
    int       n_err  = 0;
    int       n_both = 0;
    logic [7:0] sc_at_flag = 8'h00;

    always @(negedge vga_clk) begin
        if (u_if.flag) begin
            n_flag++;
            sc_at_flag = u_if.scancode;
        end
        if (u_if.frame_err) n_err++;
        if (u_if.flag && u_if.frame_err) n_both++;
    end

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        int         exp_flag;
        int         exp_err;
        logic [7:0] exp_sc;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge vga_clk);
    endtask

    // Sends the first nbits bits of a frame; glitch_bit >= 0 inserts a
    // 4-cycle low pulse on ps2_clk inside that bit's high phase.
    task automatic send_frame(input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input int nbits,
                              input int glitch_bit);
        logic [10:0] bits;
        logic        par;
        par  = bad_par ? ^d : ~^d;
        bits = {~bad_stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            u_if.ps2_data = bits[i];
            if (i == glitch_bit) begin
                cycles(H / 2);
                u_if.ps2_clk = 1'b0;
                cycles(4);
                u_if.ps2_clk = 1'b1;
                cycles(H / 2);
            end else begin
                cycles(H);
            end
            u_if.ps2_clk = 1'b0;
            cycles(H);
            u_if.ps2_clk = 1'b1;
        end
        u_if.ps2_data = 1'b1;
        cycles(H);
    endtask

    int f0, e0;

    initial begin
        vecs[0] = '{8'h2B, 1'b0, 1'b0, 1, 0, 8'h2B};
        vecs[1] = '{8'h15, 1'b1, 1'b0, 0, 1, 8'h2B};
        vecs[2] = '{8'h15, 1'b0, 1'b1, 0, 1, 8'h2B};
`ifdef PS2_BREAK_FILTER_EN
        vecs[3] = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h2B};
        vecs[4] = '{8'h2B, 1'b0, 1'b0, 0, 0, 8'h2B};
`else
        vecs[3] = '{8'hF0, 1'b0, 1'b0, 1, 0, 8'hF0};
        vecs[4] = '{8'h2B, 1'b0, 1'b0, 1, 0, 8'h2B};
`endif
        vecs[5] = '{8'hE0, 1'b0, 1'b0, 1, 0, 8'hE0};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 1, 0, 8'h00};

        u_if.ps2_clk  = 1'b1;
        u_if.ps2_data = 1'b1;
        cycles(5);
        @(negedge vga_clk);
        chk("reset_scancode", int'(u_if.scancode), 0);
        chk("reset_flag", int'(u_if.flag), 0);
        chk("reset_err", int'(u_if.frame_err), 0);
        chk("reset_busy", int'(u_if.busy), 0);
        reset = 1'b0;
        cycles(20);

        for (int v = 0; v < 7; v++) begin
            f0 = n_flag;
            e0 = n_err;
            send_frame(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop, 11, -1);
            @(negedge vga_clk);
            chk($sformatf("vec%0d_flags", v), n_flag - f0, vecs[v].exp_flag);
            chk($sformatf("vec%0d_errs", v), n_err - e0, vecs[v].exp_err);
            chk($sformatf("vec%0d_scancode", v), int'(u_if.scancode), int'(vecs[v].exp_sc));
            if (vecs[v].exp_flag == 1)
                chk($sformatf("vec%0d_sc_at_flag", v), int'(sc_at_flag), int'(vecs[v].exp_sc));
        end

        // Truncated frame followed by a long idle line -> timeout.
        f0 = n_flag;
        e0 = n_err;
        send_frame(8'h1F, 1'b0, 1'b0, 6, -1);
        @(negedge vga_clk);
        chk("to_busy_mid", int'(u_if.busy), 1);
        cycles(5200);
        @(negedge vga_clk);
        chk("to_errs", n_err - e0, 1);
        chk("to_flags", n_flag - f0, 0);
        chk("to_busy_after", int'(u_if.busy), 0);
        f0 = n_flag;
        send_frame(8'h33, 1'b0, 1'b0, 11, -1);
        @(negedge vga_clk);
        chk("after_to_flags", n_flag - f0, 1);
        chk("after_to_scancode", int'(u_if.scancode), 8'h33);

        // Glitches on ps2_clk in IDLE and mid-frame are filtered out.
        e0 = n_err;
        u_if.ps2_clk = 1'b0;
        cycles(4);
        u_if.ps2_clk = 1'b1;
        cycles(H);
        @(negedge vga_clk);
        chk("glitch_idle_busy", int'(u_if.busy), 0);
        f0 = n_flag;
        send_frame(8'h22, 1'b0, 1'b0, 11, 3);
        @(negedge vga_clk);
        chk("glitch_flags", n_flag - f0, 1);
        chk("glitch_errs", n_err - e0, 0);
        chk("glitch_scancode", int'(u_if.scancode), 8'h22);

        // Reset mid-frame after the 4th data bit.
        f0 = n_flag;
        e0 = n_err;
        send_frame(8'h2D, 1'b0, 1'b0, 5, -1);
        @(negedge vga_clk);
        reset = 1'b1;
        cycles(3);
        @(negedge vga_clk);
        reset = 1'b0;
        cycles(5500);
        @(negedge vga_clk);
        chk("rst_mid_flags", n_flag - f0, 0);
        chk("rst_mid_errs", n_err - e0, 0);
        chk("rst_mid_scancode", int'(u_if.scancode), 0);
        chk("rst_mid_busy", int'(u_if.busy), 0);
        f0 = n_flag;
        send_frame(8'h34, 1'b0, 1'b0, 11, -1);
        @(negedge vga_clk);
        chk("after_rst_flags", n_flag - f0, 1);
        chk("after_rst_scancode", int'(u_if.scancode), 8'h34);

        chk("flag_err_overlap", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
